mul_xxbit_booth_hs: RTL and testbench
=====================================

# mul_xxbit_booth_hs

Iterative radix-4 Booth multiplier with a parametrised width, per-operation signed/unsigned mode, valid/ready handshakes on input and output, early termination, and a flush. It retires one Booth digit per clock and is the handshake-capable successor of the free-running fixed-signed Booth multiplier. It sits in the common multiplier library, where execution units use it as a multi-cycle MUL resource.

## Interface
- DATA_WIDTH, 8, operand width; must be even and ≥ 4.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_flush  in  1  abort the current operation.
- i_in_valid  in  1  operands are valid.
- o_in_ready  out  1  block can accept operands.
- i_sign  in  1  1 = signed × signed, 0 = unsigned × unsigned.
- i_num_a  in  DATA_WIDTH  multiplicand.
- i_num_b  in  DATA_WIDTH  multiplier.
- o_out_valid  out  1  result is valid.
- i_out_ready  in  1  consumer accepts the result.
- o_res  out  2*DATA_WIDTH  exact product.
- o_steps  out  $clog2(DATA_WIDTH/2+2)  number of Booth steps executed for o_res.

## Operation
- FSM states: IDLE, CALC, DONE.
- Priority: i_rst > i_flush > handshake.

IDLE
- o_in_ready = 1.
- On i_in_valid, latch the operands:
  - A register (2W bits) = i_num_a, sign-extended if i_sign, else zero-extended.
  - B register (W+3 bits) = {ext2(i_num_b), i_num_b, 1'b0}.
    - ext2 is two copies of the MSB if i_sign, else 2'b00.
    - The LSB is the Booth guard bit.
  - Accumulator = 0; step counter = 0.
  - Next state: CALC.

CALC (one step per cycle)
- Recode B[2:0] into a partial product:
  - 000, 111 → 0
  - 001, 010 → +A
  - 011 → +2A
  - 100 → −2A
  - 101, 110 → −A
- Negation is ~x + 1. The +1 enters as the adder carry-in, in the same cycle.
- acc ← acc + pp, modulo 2^(2W); carry-out is discarded.
- A ← A << 2.
- B ← B >>> 2 (arithmetic shift).
- step counter += 1.
- Go to DONE when either is true after this step:
  - the post-update step counter equals W/2+1, or
  - all W+3 bits of the post-shift B are equal (all 0s or all 1s), meaning every remaining digit is 0.
- At least one step always executes.

DONE
- o_out_valid = 1; o_res = acc; o_steps = counter.
- Both outputs are held stable until i_out_ready.
- On i_out_ready → IDLE.

Other rules
- o_in_ready = (state == IDLE) & ~i_rst. It is low in CALC and DONE; there is no overlap of operations.
- i_sign, i_num_a and i_num_b are sampled only at acceptance. Later changes are ignored.
- i_flush in any state:
  - next state is IDLE; o_out_valid ← 0; o_res ← 0; o_steps ← 0.
  - An i_in_valid in the same cycle is not accepted.
- i_rst (any state, including mid-CALC) sets:
  - state = IDLE
  - o_out_valid = 0
  - o_res = 0
  - o_steps = 0
  - internal A, B, acc and counter = 0
  - o_in_ready = 0 while i_rst is high

## Timing
- Acceptance happens at an edge with i_in_valid & o_in_ready. The first CALC cycle follows immediately.
- With s steps (1 ≤ s ≤ W/2+1), o_out_valid rises s+1 cycles after the accepting edge.
  - W = 8: worst case 6 cycles, best case 2 cycles.
- Result retired with i_out_ready high at the first DONE cycle → o_in_ready is high on the next cycle.
  - Minimum issue interval = s + 2 cycles.
- i_out_ready held low → DONE persists indefinitely; o_res and o_steps do not change.
- All outputs are registered or decoded from state only. There is no combinational input-to-output path except i_rst → o_in_ready.

## Test plan
- W=8, signed, a=0x05, b=0xFD (5 × −3), ready high:
  - o_res=0xFFF1, o_steps=2.
  - o_out_valid 3 cycles after acceptance.
- W=8, unsigned, a=0xFF, b=0xFF:
  - o_res=0xFE01, o_steps=5 (maximum).
  - The same operands with signed mode → o_res=0x0001.
- W=8, signed, a=0x80, b=0x80:
  - o_res=0x4000, o_steps=4 (early termination on all-ones B).
- b=0x00, any a and any mode:
  - o_res=0x0000, o_steps=1.
  - o_out_valid 2 cycles after acceptance.
- Backpressure: hold i_out_ready low for 10 cycles in DONE.
  - o_res and o_out_valid stay stable; o_in_ready stays 0.
  - A new i_in_valid is not accepted until one cycle after the result is retired.
- Abort: i_flush (or i_rst) pulsed in the second CALC cycle of 0xFF×0xFF with i_in_valid high.
  - Next cycle: IDLE, o_out_valid=0, o_res=0.
  - No acceptance in the flush cycle.
  - A following 0x05×0xFD completes correctly.
- Randomised run, W ∈ {4, 8, 16, 32}, both modes:
  - Check against a reference product; compare the o_steps bound as well.

Source files
------------

// File: rtl/mul_xxbit_booth_hs.sv
// rtl/mul_xxbit_booth_hs.sv - iterative radix-4 Booth multiplier with valid/ready handshakes
module mul_xxbit_booth_hs #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_flush,
  input  logic                                 i_in_valid,
  output logic                                 o_in_ready,
  input  logic                                 i_sign,
  input  logic [DATA_WIDTH-1:0]                i_num_a,
  input  logic [DATA_WIDTH-1:0]                i_num_b,
  output logic                                 o_out_valid,
  input  logic                                 i_out_ready,
  output logic [2*DATA_WIDTH-1:0]              o_res,
  output logic [$clog2(DATA_WIDTH/2+2)-1:0]    o_steps
);

  localparam int W  = DATA_WIDTH;
  localparam int AW = 2 * W;
  localparam int BW = W + 3;
  localparam int SW = $clog2(W / 2 + 2);
  localparam logic [SW-1:0] MAX_STEPS = SW'(W / 2 + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] a_reg;
  logic [AW-1:0] acc;
  logic [BW-1:0] b_reg;
  logic [SW-1:0] cnt;
  logic          out_valid;
  logic [AW-1:0] res;
  logic [SW-1:0] steps;

  logic [AW-1:0] mag;
  logic [AW-1:0] addend;
  logic [AW-1:0] acc_next;
  logic          neg;
  logic [BW-1:0] b_next;
  logic [SW-1:0] cnt_next;
  logic          finish;

  // Negative digits add ~mag with the +1 supplied as carry-in.
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (b_reg[2:0])
      3'b001, 3'b010: mag = a_reg;
      3'b011:         mag = {a_reg[AW-2:0], 1'b0};
      3'b100: begin
        mag = {a_reg[AW-2:0], 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = a_reg;
        neg = 1'b1;
      end
      default:        mag = '0;
    endcase
    addend   = neg ? ~mag : mag;
    acc_next = acc + addend + AW'(neg);
    b_next   = {{2{b_reg[BW-1]}}, b_reg[BW-1:2]};
    cnt_next = cnt + SW'(1);
    // A uniform B means every remaining digit recodes to zero.
    finish   = (cnt_next == MAX_STEPS) || (&b_next) || ~(|b_next);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      res       <= '0;
      steps     <= '0;
    end else if (i_flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      res       <= '0;
      steps     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_in_valid) begin
            a_reg <= i_sign ? {{W{i_num_a[W-1]}}, i_num_a} : {{W{1'b0}}, i_num_a};
            b_reg <= {{2{i_sign & i_num_b[W-1]}}, i_num_b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc   <= acc_next;
          a_reg <= {a_reg[AW-3:0], 2'b00};
          b_reg <= b_next;
          cnt   <= cnt_next;
          if (finish) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            res       <= acc_next;
            steps     <= cnt_next;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (state == S_IDLE) & ~i_rst;
  assign o_out_valid = out_valid;
  assign o_res       = res;
  assign o_steps     = steps;

endmodule

// File: tb/tb_mul_xxbit_booth_hs.sv
// tb/tb_mul_xxbit_booth_hs.sv - directed and randomised checks of mul_xxbit_booth_hs
module tb_mul_xxbit_booth_hs;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        sign;
  logic [31:0] num_a;
  logic [31:0] num_b;
  logic        out_ready;

  logic [3:0]  in_ready_g;
  logic [3:0]  out_valid_g;
  logic [63:0] res_g   [4];
  logic [7:0]  steps_g [4];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instance per width 4, 8, 16, 32; directed tests observe the 8-bit one (index 1).
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int WG = 4 << g;
    localparam int SG = $clog2(WG / 2 + 2);
    logic [2*WG-1:0] r;
    logic [SG-1:0]   s;
    logic            ir;
    logic            ov;
    mul_xxbit_booth_hs #(.DATA_WIDTH(WG)) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_flush     (flush),
      .i_in_valid  (in_valid),
      .o_in_ready  (ir),
      .i_sign      (sign),
      .i_num_a     (num_a[WG-1:0]),
      .i_num_b     (num_b[WG-1:0]),
      .o_out_valid (ov),
      .i_out_ready (out_ready),
      .o_res       (r),
      .o_steps     (s)
    );
    assign res_g[g]       = 64'(r);
    assign steps_g[g]     = 8'(s);
    assign in_ready_g[g]  = ir;
    assign out_valid_g[g] = ov;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input int w, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m1;
    logic [63:0] m2;
    logic [63:0] ea;
    logic [63:0] eb;
    m1 = (64'd1 << w) - 64'd1;
    m2 = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    ea = 64'(a) & m1;
    eb = 64'(b) & m1;
    if (s && ea[w-1]) ea = ea | ~m1;
    if (s && eb[w-1]) eb = eb | ~m1;
    return (ea * eb) & m2;
  endfunction

  // Issue on the 8-bit instance with out_ready high; lat is the cycle index from the acceptance cycle.
  task automatic run8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic [63:0] er, input int es);
    int lat;
    chk({tag, "_ready"}, 64'(in_ready_g[1]), 64'd1);
    sign = s; num_a = 32'(a); num_b = 32'(b);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid_g[1] && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(es + 1));
    chk({tag, "_res"}, res_g[1], er);
    chk({tag, "_steps"}, 64'(steps_g[1]), 64'(es));
    tick();
    chk({tag, "_idle"}, 64'(in_ready_g[1]), 64'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; sign = 1'b0;
    num_a = '0; num_b = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready_g[1]), 64'd0);
    chk("rst_out_valid", 64'(out_valid_g[1]), 64'd0);
    chk("rst_res", res_g[1], 64'd0);
    chk("rst_steps", 64'(steps_g[1]), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(in_ready_g[1]), 64'd1);

    run8("s5xm3", 1'b1, 8'h05, 8'hFD, 64'hFFF1, 2);
    run8("uffxff", 1'b0, 8'hFF, 8'hFF, 64'hFE01, 5);
    run8("sffxff", 1'b1, 8'hFF, 8'hFF, 64'h0001, 1);
    run8("s80x80", 1'b1, 8'h80, 8'h80, 64'h4000, 4);
    run8("ub0", 1'b0, 8'h5A, 8'h00, 64'h0000, 1);
    run8("sb0", 1'b1, 8'hC3, 8'h00, 64'h0000, 1);

    // Backpressure with a second request already pending.
    sign = 1'b1; num_a = 32'h05; num_b = 32'hFD; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    sign = 1'b0; num_a = 32'hFF; num_b = 32'hFF;
    n = 0;
    while (!out_valid_g[1] && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_res", res_g[1], 64'hFFF1);
      chk("bp_valid", 64'(out_valid_g[1]), 64'd1);
      chk("bp_in_ready", 64'(in_ready_g[1]), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_retire_valid", 64'(out_valid_g[1]), 64'd0);
    chk("bp_retire_ready", 64'(in_ready_g[1]), 64'd1);
    tick();
    chk("bp_accept", 64'(in_ready_g[1]), 64'd0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid_g[1] && n < 20) begin
      tick();
      n++;
    end
    chk("bp_second_res", res_g[1], 64'hFE01);
    chk("bp_second_steps", 64'(steps_g[1]), 64'd5);
    tick();

    // Flush in the second CALC cycle with in_valid held high.
    sign = 1'b0; num_a = 32'hFF; num_b = 32'hFF; in_valid = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    chk("fl_valid", 64'(out_valid_g[1]), 64'd0);
    chk("fl_res", res_g[1], 64'd0);
    chk("fl_idle", 64'(in_ready_g[1]), 64'd1);
    sign = 1'b1; num_a = 32'h05; num_b = 32'hFD;
    tick();
    chk("fl_no_accept", 64'(in_ready_g[1]), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    run8("fl_after", 1'b1, 8'h05, 8'hFD, 64'hFFF1, 2);

    // Reset in the second CALC cycle with in_valid held high.
    sign = 1'b0; num_a = 32'hFF; num_b = 32'hFF; in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rs_ready_low", 64'(in_ready_g[1]), 64'd0);
    tick();
    chk("rs_valid", 64'(out_valid_g[1]), 64'd0);
    chk("rs_res", res_g[1], 64'd0);
    chk("rs_steps", 64'(steps_g[1]), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rs_idle", 64'(in_ready_g[1]), 64'd1);
    run8("rs_after", 1'b1, 8'h05, 8'hFD, 64'hFFF1, 2);

    // Randomised run across all widths and both modes.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 24; t++) begin
      sign = 1'($urandom_range(0, 1)); num_a = $urandom; num_b = $urandom;
      if (t == 0) num_b = '0;
      in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!(&out_valid_g) && n < 40) begin
        tick();
        n++;
      end
      chk("rnd_all_valid", 64'(&out_valid_g), 64'd1);
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("rnd_res_w%0d", 4 << g), res_g[g], ref_mul(4 << g, sign, num_a, num_b));
        chk($sformatf("rnd_steps_w%0d", 4 << g),
            64'((steps_g[g] >= 8'd1) && (steps_g[g] <= 8'((2 << g) + 1))), 64'd1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
